msrv32_integer_file: RTL and testbench
======================================

# msrv32_integer_file

Architectural integer register file (x0–x31) of the RISC-V 32I core. It sits directly downstream of the write-enable generator in the write-back stage and consumes its `wr_en_int_file_out` gate as the write strobe. It supplies the two source operands to the decode/execute stage through combinational read ports. An internal write-to-read bypass lets an instruction reading a register see the value being written back in the same cycle.

## Interface
- `XLEN`, 32: data width of every register.
- `REGS`, 32: number of registers. The address width is fixed at 5 bits.
- `clk_in` input 1: single core clock. All state updates on the rising edge.
- `rst_n_in` input 1: asynchronous, active-low reset.
- `rs1_addr_in` input 5: read port 1 address.
- `rs2_addr_in` input 5: read port 2 address.
- `rd_addr_in` input 5: write address from the write-back pipeline register.
- `wr_en_in` input 1: write strobe. Connected to `wr_en_int_file_out` of the write-enable generator, which is already flush-gated.
- `rd_in` input XLEN: write-back data.
- `rs1_out` output XLEN: read data, port 1.
- `rs2_out` output XLEN: read data, port 2.

## Operation
- **Storage:** array of `REGS` × `XLEN` flops. Location 0 is not implemented as storage.
- **Write:**
  - On a rising `clk_in` with `wr_en_in`=1 and `rd_addr_in`≠0, `reg[rd_addr_in]` ← `rd_in`.
  - A write to x0 is silently discarded.
  - `wr_en_in`=0 leaves every register unchanged, whatever values are on `rd_addr_in` and `rd_in`.
- **Read:** combinational and independent per port. For port n:
  - If `rsn_addr_in`=0, `rsn_out` = 0.
  - Else if `wr_en_in`=1 and `rsn_addr_in`=`rd_addr_in`, `rsn_out` = `rd_in` (bypass).
  - Else `rsn_out` = `reg[rsn_addr_in]`.
- **Simultaneous events:**
  - Both ports may address the same register; both return the same value, including the bypassed value.
  - A read and a write to the same register in the same cycle returns the new data through the bypass. The array updates at the edge.
  - A write to x0 with a read of x0 returns 0. The bypass never applies to address 0.
- **Flush:** there is no flush input. Flush is already folded into `wr_en_in` upstream. A flushed instruction appears as `wr_en_in`=0 and must cause no update and no bypass.
- **Reset:**
  - `rst_n_in` low asynchronously clears x1–x31 to 0, independent of the clock.
  - While reset is held, writes are ignored.
  - Read outputs follow the combinational rules during reset: stored values read 0, but the bypass path still reflects `wr_en_in`/`rd_in`. Upstream keeps `wr_en_in` low during reset.
  - Deassertion is assumed synchronous to `clk_in` externally. The first write is accepted on the first rising edge with `rst_n_in` high.
  - Reset asserted mid-operation, between edges, clears the array immediately. No partial write survives.

## Timing
- **Write latency:** data is visible from the array one cycle after the strobed edge, and zero cycles via the bypass.
- **Read latency:** zero cycles, purely combinational from addresses, `wr_en_in`, `rd_addr_in` and `rd_in`.
- **Reset values:** `rs1_out`/`rs2_out` = 0 whenever reset is asserted and `wr_en_in`=0. All registers read 0 after reset.
- **Critical path:** address decode → 32:1 mux → bypass mux. There is no internal pipelining, because the bypass must be single-cycle.

## Test plan
- **Reset clear:** write 0xDEADBEEF to x5, then pulse `rst_n_in` low mid-cycle → `rs1_out` with `rs1_addr_in`=5 reads 0 immediately, before any clock edge.
- **Basic write/read:** write 0x12345678 to x1 and 0xA5A5A5A5 to x31, then read rs1=1, rs2=31 → 0x12345678 and 0xA5A5A5A5. Read x2 → 0.
- **x0 hardwired:** `wr_en_in`=1, `rd_addr_in`=0, `rd_in`=0xFFFFFFFF, rs1=rs2=0 → both outputs 0 during the cycle and after the edge.
- **Bypass:** x7 holds 0x11, then in one cycle `wr_en_in`=1, rd=7, `rd_in`=0x22, rs1=7, rs2=7 → both 0x22 combinationally. The next cycle, with `wr_en_in`=0, both still read 0x22.
- **Flushed write:** `wr_en_in`=0, rd=9, `rd_in`=0x55, rs1=9 → reads the old value 0. After the edge x9 is still 0.
- **Back-to-back writes:** write x3=1, x3=2, x3=3 on consecutive edges while reading rs1=3 → outputs 1, 2, 3 in those cycles via the bypass, then 3 after `wr_en_in` drops.

Source files
------------

// File: rtl/msrv32_integer_file.sv
// msrv32_integer_file: RV32I architectural register file x0..x31.
// Two combinational read ports with a write-to-read bypass, one write port
// gated by the (already flush-qualified) write strobe. x0 has no storage
// and always reads zero.
module msrv32_integer_file #(
  parameter int XLEN = 32,
  parameter int REGS = 32
) (
  input  logic            clk_in,
  input  logic            rst_n_in,
  input  logic [4:0]      rs1_addr_in,
  input  logic [4:0]      rs2_addr_in,
  input  logic [4:0]      rd_addr_in,
  input  logic            wr_en_in,
  input  logic [XLEN-1:0] rd_in,
  output logic [XLEN-1:0] rs1_out,
  output logic [XLEN-1:0] rs2_out
);

  // Storage for x1..x(REGS-1); location 0 is intentionally absent.
  logic [XLEN-1:0] regs_q [1:REGS-1];

  logic            wr_hit_s;
  logic [XLEN-1:0] rs1_d;
  logic [XLEN-1:0] rs2_d;

  // A write is real only when strobed, not aimed at x0 and inside the array.
  always_comb begin
    wr_hit_s = 1'b0;
    if (wr_en_in && (rd_addr_in != 5'd0) && (int'(rd_addr_in) < REGS)) begin
      wr_hit_s = 1'b1;
    end else begin
      wr_hit_s = 1'b0;
    end
  end

  // Array update; reset clears every register asynchronously and wins over writes.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      for (int i = 1; i < REGS; i++) begin
        regs_q[i] <= '0;
      end
    end else if (wr_hit_s) begin
      regs_q[rd_addr_in] <= rd_in;
    end
  end

  // Read port 1: x0 -> zero, same-cycle write -> bypass, otherwise array.
  always_comb begin
    rs1_d = '0;
    if (rs1_addr_in == 5'd0) begin
      rs1_d = '0;
    end else if (int'(rs1_addr_in) >= REGS) begin
      rs1_d = '0;
    end else if (wr_en_in && (rs1_addr_in == rd_addr_in)) begin
      rs1_d = rd_in;
    end else begin
      rs1_d = regs_q[rs1_addr_in];
    end
  end

  // Read port 2: same selection rules as port 1, fully independent.
  always_comb begin
    rs2_d = '0;
    if (rs2_addr_in == 5'd0) begin
      rs2_d = '0;
    end else if (int'(rs2_addr_in) >= REGS) begin
      rs2_d = '0;
    end else if (wr_en_in && (rs2_addr_in == rd_addr_in)) begin
      rs2_d = rd_in;
    end else begin
      rs2_d = regs_q[rs2_addr_in];
    end
  end

  // Reads must be zero-latency for the bypass to work, so outputs stay combinational.
  assign rs1_out = rs1_d;
  assign rs2_out = rs2_d;

endmodule

// File: tb/tb_msrv32_integer_file.sv
// tb_msrv32_integer_file: directed + random checks of the integer register file.
// Expected values are queued when stimulus is applied and compared shortly
// after, well away from the rising clock edge.
module tb_msrv32_integer_file;

  logic        clk_in;
  logic        rst_n_in;
  logic [4:0]  rs1_addr_in;
  logic [4:0]  rs2_addr_in;
  logic [4:0]  rd_addr_in;
  logic        wr_en_in;
  logic [31:0] rd_in;
  logic [31:0] rs1_out;
  logic [31:0] rs2_out;

  int checks;
  int failures;

  typedef struct {
    string       tag;
    logic [31:0] e1;
    logic [31:0] e2;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] model [32];

  msrv32_integer_file #(.XLEN(32), .REGS(32)) dut (
    .clk_in      (clk_in),
    .rst_n_in    (rst_n_in),
    .rs1_addr_in (rs1_addr_in),
    .rs2_addr_in (rs2_addr_in),
    .rd_addr_in  (rd_addr_in),
    .wr_en_in    (wr_en_in),
    .rd_in       (rd_in),
    .rs1_out     (rs1_out),
    .rs2_out     (rs2_out)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  task automatic clear_model();
    for (int i = 0; i < 32; i++) model[i] = 32'd0;
  endtask

  task automatic drive(input logic we, input logic [4:0] rd, input logic [31:0] d,
                       input logic [4:0] a1, input logic [4:0] a2);
    wr_en_in    = we;
    rd_addr_in  = rd;
    rd_in       = d;
    rs1_addr_in = a1;
    rs2_addr_in = a2;
    if (we && rd != 5'd0 && rst_n_in) model[rd] = d;
  endtask

  task automatic push(input string tag, input logic [31:0] e1, input logic [31:0] e2);
    exp_t e;
    e.tag = tag;
    e.e1  = e1;
    e.e2  = e2;
    sb.push_back(e);
  endtask

  task automatic check_now();
    exp_t e;
    #1;
    if (sb.size() == 0) begin
      checks++;
      failures++;
      $error("FAIL sb_empty observed=none expected=entry");
    end else begin
      e = sb.pop_front();
      checks++;
      assert (rs1_out === e.e1) else begin
        failures++;
        $error("FAIL %s rs1 observed=%h expected=%h", e.tag, rs1_out, e.e1);
      end
      checks++;
      assert (rs2_out === e.e2) else begin
        failures++;
        $error("FAIL %s rs2 observed=%h expected=%h", e.tag, rs2_out, e.e2);
      end
    end
  endtask

  task automatic step(input logic we, input logic [4:0] rd, input logic [31:0] d,
                      input logic [4:0] a1, input logic [4:0] a2,
                      input string tag, input logic [31:0] e1, input logic [31:0] e2);
    @(negedge clk_in);
    drive(we, rd, d, a1, a2);
    push(tag, e1, e2);
    check_now();
  endtask

  initial begin
    logic        we;
    logic [4:0]  rd, a1, a2;
    logic [31:0] d, e1, e2;

    checks   = 0;
    failures = 0;
    clear_model();
    rst_n_in = 1'b1;
    drive(1'b0, 5'd0, 32'd0, 5'd5, 5'd31);
    #1 rst_n_in = 1'b0;
    push("reset_state", 32'd0, 32'd0);
    check_now();

    // Bypass still visible during reset; the write itself is dropped.
    step(1'b1, 5'd4, 32'h0000_0077, 5'd4, 5'd0, "rst_bypass", 32'h0000_0077, 32'd0);
    step(1'b0, 5'd0, 32'd0, 5'd4, 5'd0, "rst_write_ignored", 32'd0, 32'd0);
    @(negedge clk_in);
    rst_n_in = 1'b1;

    // Mid-cycle reset clears stored data immediately.
    step(1'b1, 5'd5, 32'hDEAD_BEEF, 5'd5, 5'd0, "wr_x5_bypass", 32'hDEAD_BEEF, 32'd0);
    step(1'b0, 5'd0, 32'd0, 5'd5, 5'd0, "rd_x5", 32'hDEAD_BEEF, 32'd0);
    #2 rst_n_in = 1'b0;
    clear_model();
    push("mid_reset", 32'd0, 32'd0);
    check_now();
    @(negedge clk_in);
    rst_n_in = 1'b1;

    // Basic write/read.
    step(1'b1, 5'd1, 32'h1234_5678, 5'd0, 5'd0, "wr_x1", 32'd0, 32'd0);
    step(1'b1, 5'd31, 32'hA5A5_A5A5, 5'd1, 5'd0, "wr_x31", 32'h1234_5678, 32'd0);
    step(1'b0, 5'd0, 32'd0, 5'd1, 5'd31, "rd_1_31", 32'h1234_5678, 32'hA5A5_A5A5);
    step(1'b0, 5'd0, 32'd0, 5'd2, 5'd0, "rd_x2", 32'd0, 32'd0);

    // x0 hardwired.
    step(1'b1, 5'd0, 32'hFFFF_FFFF, 5'd0, 5'd0, "x0_wr", 32'd0, 32'd0);
    step(1'b0, 5'd0, 32'hFFFF_FFFF, 5'd0, 5'd0, "x0_after", 32'd0, 32'd0);

    // Bypass on both ports, then stored value.
    step(1'b1, 5'd7, 32'h0000_0011, 5'd0, 5'd0, "wr_x7", 32'd0, 32'd0);
    step(1'b1, 5'd7, 32'h0000_0022, 5'd7, 5'd7, "byp_x7", 32'h0000_0022, 32'h0000_0022);
    step(1'b0, 5'd7, 32'd0, 5'd7, 5'd7, "x7_after", 32'h0000_0022, 32'h0000_0022);

    // Flushed write: no bypass, no update.
    step(1'b0, 5'd9, 32'h0000_0055, 5'd9, 5'd7, "flush_x9", 32'd0, 32'h0000_0022);
    step(1'b0, 5'd0, 32'd0, 5'd9, 5'd0, "x9_after", 32'd0, 32'd0);

    // Back-to-back writes to x3.
    step(1'b1, 5'd3, 32'd1, 5'd3, 5'd7, "b2b_1", 32'd1, 32'h0000_0022);
    step(1'b1, 5'd3, 32'd2, 5'd3, 5'd7, "b2b_2", 32'd2, 32'h0000_0022);
    step(1'b1, 5'd3, 32'd3, 5'd3, 5'd7, "b2b_3", 32'd3, 32'h0000_0022);
    step(1'b0, 5'd3, 32'd0, 5'd3, 5'd3, "b2b_done", 32'd3, 32'd3);

    // Ports independent: one bypassed, the other from the array.
    step(1'b1, 5'd31, 32'hCAFE_F00D, 5'd31, 5'd1, "byp_rs1_only", 32'hCAFE_F00D, 32'h1234_5678);
    step(1'b0, 5'd0, 32'd0, 5'd1, 5'd31, "x31_after", 32'h1234_5678, 32'hCAFE_F00D);

    // Random traffic against a reference array.
    for (int n = 0; n < 40; n++) begin
      we = 1'($urandom_range(0, 1));
      rd = 5'($urandom_range(0, 31));
      d  = $urandom;
      a1 = 5'($urandom_range(0, 31));
      a2 = (n % 4 == 0) ? rd : 5'($urandom_range(0, 31));
      e1 = (a1 == 5'd0) ? 32'd0 : ((we && a1 == rd) ? d : model[a1]);
      e2 = (a2 == 5'd0) ? 32'd0 : ((we && a2 == rd) ? d : model[a2]);
      step(we, rd, d, a1, a2, "random", e1, e2);
    end

    @(negedge clk_in);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
